mesi_bus_initiator: RTL and testbench

- Issues MESI coherence transactions for one cache onto the shared snoop bus: BusRd for a read miss, BusRdX for a write miss, Invalidate for a write hit on a SHARED line.
- It is the requesting end of the snoop protocol that the per-cache controllers respond to.
- Arbitrates for the bus, drives Address_Com plus one command for one cycle, and collects the Shared/Flush responses.
- Obtains the fill line from the flushing owner or from memory, then returns the data and the final MESI state to the cache.

---
 rtl/mesi_bus_initiator.sv | 206 ++++++++++++++++++++
 tb/tb_mesi_bus_initiator.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesi_bus_initiator.sv
// mesi_bus_initiator: requesting end of the MESI snoop bus for one cache.
// Turns a cache miss/upgrade into a single bus transaction (BusRd, BusRdX or
// Invalidate), collects the Shared/Flush responses, fetches the line from the
// flushing owner or from memory, and reports fill data plus the final MESI state.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   Req_valid/Req_type/Req_addr     cache request (accepted when Req_ready)
//   Req_ready                       high only while idle
//   Done/Error                      one-cycle completion pulse (Error on timeout)
//   Fill_data/Fill_MESI_state       fill word and final state, valid with Done
//   Bus_req/Bus_grant               bus arbitration handshake
//   BusRd/BusRdX/Invalidate         one-cycle snoop command
//   Address_Com                     snoop address, driven in ADDR and SNOOP
//   Shared/Flush/Snoop_done         snooper responses
//   Data_Bus_Com                    data supplied by a flushing owner
//   Mem_req/Mem_ack/Mem_data        memory read handshake
module mesi_bus_initiator #(
  parameter int unsigned ADDRESSSIZE = 32,
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned TMR_W       = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   Req_valid,
  input  logic [1:0]             Req_type,
  input  logic [ADDRESSSIZE-1:0] Req_addr,
  output logic                   Req_ready,
  output logic                   Done,
  output logic                   Error,
  output logic [ADDRESSSIZE-1:0] Fill_data,
  output logic [1:0]             Fill_MESI_state,
  output logic                   Bus_req,
  input  logic                   Bus_grant,
  output logic                   BusRd,
  output logic                   BusRdX,
  output logic                   Invalidate,
  output logic [ADDRESSSIZE-1:0] Address_Com,
  input  logic                   Shared,
  input  logic                   Flush,
  input  logic                   Snoop_done,
  input  logic [ADDRESSSIZE-1:0] Data_Bus_Com,
  output logic                   Mem_req,
  input  logic                   Mem_ack,
  input  logic [ADDRESSSIZE-1:0] Mem_data
);

  localparam logic [1:0] MesiI = 2'b00;
  localparam logic [1:0] MesiS = 2'b01;
  localparam logic [1:0] MesiE = 2'b10;
  localparam logic [1:0] MesiM = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StAddr,
    StSnoop,
    StMem,
    StComplete
  } state_e;

  state_e                 r_state, w_state_nxt;
  logic [1:0]             r_type;
  logic [ADDRESSSIZE-1:0] r_addr;
  logic [ADDRESSSIZE-1:0] r_fill;
  logic [1:0]             r_mesi, w_mesi_nxt;
  logic                   r_shared;
  logic                   r_err, w_err_nxt;
  logic [TMR_W-1:0]       r_tmr;

  logic w_accept;
  logic w_cap_bus;
  logic w_cap_mem;
  logic w_is_upg;
  logic w_is_wr;
  logic w_tmo;

  // Type 11 falls through to the read path because only 01 and 10 are decoded.
  assign w_is_upg = (r_type == 2'b10);
  assign w_is_wr  = (r_type == 2'b01);
  // Counter starts at 0 on the first SNOOP/MEM cycle, so this fires on the
  // TIMEOUT-th cycle and COMPLETE lands exactly TIMEOUT cycles after entry.
  assign w_tmo    = (r_tmr == TMR_W'(TIMEOUT - 1));

  assign Fill_data       = r_fill;
  assign Fill_MESI_state = r_mesi;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_cap_bus   = 1'b0;
    w_cap_mem   = 1'b0;
    w_mesi_nxt  = r_mesi;
    w_err_nxt   = r_err;
    Req_ready   = 1'b0;
    Bus_req     = 1'b0;
    BusRd       = 1'b0;
    BusRdX      = 1'b0;
    Invalidate  = 1'b0;
    Mem_req     = 1'b0;
    Done        = 1'b0;
    Error       = 1'b0;
    Address_Com = '0;
    case (r_state)
      StIdle: begin
        Req_ready = 1'b1;
        if (Req_valid) begin
          w_accept    = 1'b1;
          w_err_nxt   = 1'b0;
          w_state_nxt = StArb;
        end
      end
      StArb: begin
        Bus_req = 1'b1;
        if (Bus_grant) w_state_nxt = StAddr;
      end
      StAddr: begin
        Bus_req     = 1'b1;
        Address_Com = r_addr;
        BusRd       = !w_is_upg && !w_is_wr;
        BusRdX      = w_is_wr;
        Invalidate  = w_is_upg;
        w_state_nxt = StSnoop;
      end
      StSnoop: begin
        Bus_req     = 1'b1;
        Address_Com = r_addr;
        if (Snoop_done) begin
          if (w_is_upg) begin
            w_mesi_nxt  = MesiM;
            w_state_nxt = StComplete;
          end else if (Flush) begin
            w_cap_bus   = 1'b1;
            w_mesi_nxt  = w_is_wr ? MesiM : MesiS;
            w_state_nxt = StComplete;
          end else begin
            w_state_nxt = StMem;
          end
        end else if (w_tmo) begin
          w_mesi_nxt  = MesiI;
          w_err_nxt   = 1'b1;
          w_state_nxt = StComplete;
        end
      end
      StMem: begin
        Bus_req = 1'b1;
        Mem_req = 1'b1;
        if (Mem_ack) begin
          w_cap_mem   = 1'b1;
          // r_shared already includes the Snoop_done cycle.
          w_mesi_nxt  = w_is_wr ? MesiM : (r_shared ? MesiS : MesiE);
          w_state_nxt = StComplete;
        end else if (w_tmo) begin
          w_mesi_nxt  = MesiI;
          w_err_nxt   = 1'b1;
          w_state_nxt = StComplete;
        end
      end
      StComplete: begin
        Bus_req     = 1'b1;
        Done        = 1'b1;
        Error       = r_err;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_type   <= 2'b00;
      r_addr   <= '0;
      r_fill   <= '0;
      r_mesi   <= MesiI;
      r_shared <= 1'b0;
      r_err    <= 1'b0;
      r_tmr    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mesi  <= w_mesi_nxt;
      r_err   <= w_err_nxt;
      if (w_accept) begin
        r_type <= Req_type;
        r_addr <= Req_addr;
      end
      if (w_accept) begin
        r_shared <= 1'b0;
      end else if (r_state == StSnoop) begin
        r_shared <= r_shared | Shared;
      end
      if (w_cap_bus) begin
        r_fill <= Data_Bus_Com;
      end else if (w_cap_mem) begin
        r_fill <= Mem_data;
      end
      // Clear on the cycle before entering SNOOP or MEM.
      if (r_state == StAddr || (r_state == StSnoop && w_state_nxt == StMem)) begin
        r_tmr <= '0;
      end else if (r_state == StSnoop || r_state == StMem) begin
        r_tmr <= r_tmr + TMR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mesi_bus_initiator.sv
// Self-checking bench for mesi_bus_initiator: a driver plays arbiter, snoopers
// and memory; a reference model computes the expected timeline and fill result
// per transaction; a monitor compares the DUT against the queued expectations.
module tb_mesi_bus_initiator;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Req_valid;
  logic [1:0]  Req_type;
  logic [31:0] Req_addr;
  logic        Req_ready;
  logic        Done;
  logic        Error;
  logic [31:0] Fill_data;
  logic [1:0]  Fill_MESI_state;
  logic        Bus_req;
  logic        Bus_grant;
  logic        BusRd;
  logic        BusRdX;
  logic        Invalidate;
  logic [31:0] Address_Com;
  logic        Shared;
  logic        Flush;
  logic        Snoop_done;
  logic [31:0] Data_Bus_Com;
  logic        Mem_req;
  logic        Mem_ack;
  logic [31:0] Mem_data;

  mesi_bus_initiator #(
    .ADDRESSSIZE(32),
    .TIMEOUT    (TIMEOUT),
    .TMR_W      (7)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .Req_valid      (Req_valid),
    .Req_type       (Req_type),
    .Req_addr       (Req_addr),
    .Req_ready      (Req_ready),
    .Done           (Done),
    .Error          (Error),
    .Fill_data      (Fill_data),
    .Fill_MESI_state(Fill_MESI_state),
    .Bus_req        (Bus_req),
    .Bus_grant      (Bus_grant),
    .BusRd          (BusRd),
    .BusRdX         (BusRdX),
    .Invalidate     (Invalidate),
    .Address_Com    (Address_Com),
    .Shared         (Shared),
    .Flush          (Flush),
    .Snoop_done     (Snoop_done),
    .Data_Bus_Com   (Data_Bus_Com),
    .Mem_req        (Mem_req),
    .Mem_ack        (Mem_ack),
    .Mem_data       (Mem_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
  endtask

  task automatic check_b(input string name, input logic got, input logic want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, want, cyc);
  endtask

  // One transaction's stimulus: request plus how the system will answer it.
  typedef struct {
    int          typ;
    logic [31:0] addr;
    int          gd;        // extra ARB cycles before grant
    int          sd;        // SNOOP cycles before Snoop_done
    bit          snoop_to;  // snoopers never answer
    logic [7:0]  shv;       // Shared value per SNOOP cycle
    bit          flush;
    logic [31:0] bus_data;
    int          md;        // MEM cycles before Mem_ack
    bit          mem_to;    // memory never answers
    logic [31:0] mem_data;
  } tx_t;

  // Expected behaviour; cycle fields are relative to acceptance (cycle 0).
  typedef struct {
    int          t0;
    int          ac;
    int          se;
    int          sdk;
    int          snoop_last;
    int          mem_lo;
    int          mem_hi;
    int          done_k;
    logic [31:0] addr;
    logic [31:0] fill;
    logic [1:0]  mesi;
    logic [1:0]  cmd;       // 0 BusRd, 1 BusRdX, 2 Invalidate
    bit          err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] last_fill = '0;
  bit          abort = 1'b0;

  function automatic exp_t model(input tx_t t, input logic [31:0] prev_fill);
    exp_t e;
    bit   upg, wr, seen;
    upg        = (t.typ == 2);
    wr         = (t.typ == 1);
    e.t0       = 0;
    e.addr     = t.addr;
    e.cmd      = upg ? 2'd2 : (wr ? 2'd1 : 2'd0);
    e.ac       = 2 + t.gd;
    e.se       = 3 + t.gd;
    e.mem_lo   = -1;
    e.mem_hi   = -1;
    e.err      = 1'b0;
    e.fill     = prev_fill;
    e.mesi     = 2'b00;
    seen       = 1'b0;
    for (int j = 0; j < 8; j++) if (j <= t.sd && t.shv[j]) seen = 1'b1;
    if (t.snoop_to) begin
      e.sdk        = -1;
      e.snoop_last = e.se + TIMEOUT - 1;
      e.done_k     = e.se + TIMEOUT;
      e.err        = 1'b1;
    end else begin
      e.sdk        = e.se + t.sd;
      e.snoop_last = e.sdk;
      if (upg) begin
        e.done_k = e.sdk + 1;
        e.mesi   = 2'b11;
      end else if (t.flush) begin
        e.done_k = e.sdk + 1;
        e.fill   = t.bus_data;
        e.mesi   = wr ? 2'b11 : 2'b01;
      end else begin
        e.mem_lo = e.sdk + 1;
        if (t.mem_to) begin
          e.mem_hi = e.mem_lo + TIMEOUT - 1;
          e.done_k = e.mem_lo + TIMEOUT;
          e.err    = 1'b1;
        end else begin
          e.mem_hi = e.mem_lo + t.md;
          e.done_k = e.mem_hi + 1;
          e.fill   = t.mem_data;
          e.mesi   = wr ? 2'b11 : (seen ? 2'b01 : 2'b10);
        end
      end
    end
    return e;
  endfunction

  function automatic tx_t mk(input int typ, input logic [31:0] addr, input int gd, input int sd,
                             input bit snoop_to, input logic [7:0] shv, input bit flush,
                             input logic [31:0] bus_data, input int md, input bit mem_to,
                             input logic [31:0] mem_data);
    tx_t t;
    t.typ = typ; t.addr = addr; t.gd = gd; t.sd = sd; t.snoop_to = snoop_to; t.shv = shv;
    t.flush = flush; t.bus_data = bus_data; t.md = md; t.mem_to = mem_to; t.mem_data = mem_data;
    return t;
  endfunction

  function automatic tx_t rand_tx();
    tx_t t;
    t.typ      = int'($urandom_range(0, 3));
    t.addr     = $urandom;
    t.gd       = int'($urandom_range(0, 5));
    t.sd       = int'($urandom_range(0, 4));
    t.snoop_to = ($urandom_range(0, 15) == 0);
    t.shv      = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
    t.flush    = 1'($urandom);
    t.bus_data = $urandom;
    t.md       = int'($urandom_range(0, 3));
    t.mem_to   = ($urandom_range(0, 15) == 0);
    t.mem_data = $urandom;
    return t;
  endfunction

  task automatic idle_inputs();
    Req_valid    = 1'b0;
    Bus_grant    = 1'b0;
    Shared       = 1'b0;
    Flush        = 1'b0;
    Snoop_done   = 1'b0;
    Mem_ack      = 1'b0;
    Data_Bus_Com = '0;
    Mem_data     = '0;
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!Req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!Req_ready) begin
      check_b("ready_wait", Req_ready, 1'b1);
      abort = 1'b1;
    end
  endtask

  // Inputs for cycle k are set at that cycle's falling edge.
  task automatic run_tx(input tx_t t);
    exp_t e;
    if (abort) return;
    @(negedge clk);
    idle_inputs();
    wait_ready();
    if (abort) return;
    e         = model(t, last_fill);
    e.t0      = cyc;
    last_fill = e.fill;
    Req_valid = 1'b1;
    Req_type  = 2'(t.typ);
    Req_addr  = t.addr;
    exp_q.push_back(e);
    for (int k = 1; k <= e.done_k; k++) begin
      @(negedge clk);
      Req_valid    = 1'($urandom);
      Req_type     = 2'($urandom);
      Req_addr     = $urandom;
      Bus_grant    = (k >= 1 + t.gd);
      Shared       = (k >= e.se && k <= e.snoop_last && (k - e.se) < 8) ? t.shv[k - e.se] : 1'b0;
      Snoop_done   = (k == e.sdk);
      Flush        = (k == e.sdk) ? t.flush :
                     ((k >= e.se && k <= e.snoop_last) ? 1'($urandom) : 1'b0);
      Data_Bus_Com = (k == e.sdk) ? t.bus_data : $urandom;
      Mem_ack      = (!t.mem_to && e.mem_lo >= 0 && k == e.mem_hi);
      Mem_data     = Mem_ack ? t.mem_data : $urandom;
    end
  endtask

  exp_t m_e;
  int   m_k;

  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() > 0 && cyc > exp_q[0].t0) begin
        m_e = exp_q[0];
        m_k = cyc - m_e.t0;
        check_b("req_ready_busy", Req_ready, 1'b0);
        check_b("bus_req_busy", Bus_req, 1'b1);
        check_b("done_timing", Done, m_k == m_e.done_k);
        check_b("error_timing", Error, (m_k == m_e.done_k) && m_e.err);
        check_b("busrd", BusRd, (m_k == m_e.ac) && (m_e.cmd == 2'd0));
        check_b("busrdx", BusRdX, (m_k == m_e.ac) && (m_e.cmd == 2'd1));
        check_b("invalidate", Invalidate, (m_k == m_e.ac) && (m_e.cmd == 2'd2));
        check_b("mem_req", Mem_req, (m_e.mem_lo >= 0) && (m_k >= m_e.mem_lo) && (m_k <= m_e.mem_hi));
        if (m_k >= m_e.ac && m_k <= m_e.snoop_last) check("address_com", Address_Com, m_e.addr);
        if (m_k == m_e.done_k) begin
          check("fill_data", Fill_data, m_e.fill);
          check("fill_mesi", 32'(Fill_MESI_state), 32'(m_e.mesi));
          void'(exp_q.pop_front());
        end
      end else begin
        check_b("done_idle", Done, 1'b0);
        check_b("error_idle", Error, 1'b0);
        if (Req_ready)
          check("idle_outputs", 32'({Bus_req, Mem_req, BusRd, BusRdX, Invalidate}), 32'd0);
      end
    end
  end

  initial begin
    idle_inputs();
    Req_type = 2'b00;
    Req_addr = '0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    check_b("rst_req_ready", Req_ready, 1'b1);
    check_b("rst_bus_req", Bus_req, 1'b0);
    check("rst_cmds", 32'({BusRd, BusRdX, Invalidate}), 32'd0);
    check_b("rst_mem_req", Mem_req, 1'b0);
    check_b("rst_done", Done, 1'b0);
    check_b("rst_error", Error, 1'b0);
    check("rst_address_com", Address_Com, 32'd0);
    check("rst_fill_data", Fill_data, 32'd0);
    check("rst_fill_mesi", 32'(Fill_MESI_state), 32'd0);
    rst_n = 1'b1;

    // Read miss, memory fill, nobody shares: E, Done at cycle 5.
    run_tx(mk(0, 32'h0000_1040, 0, 0, 0, 8'h00, 0, 32'h0, 0, 0, 32'hDEAD_BEEF));
    // Read miss, Shared in first SNOOP cycle, owner flushes: S.
    run_tx(mk(0, 32'h0000_2080, 0, 2, 0, 8'h01, 1, 32'h1234_5678, 0, 0, 32'h0));
    // Upgrade: Invalidate only, fill unchanged, M.
    run_tx(mk(2, 32'h0000_0080, 0, 0, 0, 8'h00, 0, 32'h0, 0, 0, 32'h0));
    // Write miss with a late grant, memory fill: M.
    run_tx(mk(1, 32'h0000_3300, 4, 1, 0, 8'h03, 0, 32'h0, 1, 0, 32'hCAFE_F00D));
    // Snoopers never respond: Error, I.
    run_tx(mk(0, 32'h0000_4400, 0, 0, 1, 8'h00, 0, 32'h0, 0, 0, 32'h0));
    // Type 11 read, memory never responds: Error, I.
    run_tx(mk(3, 32'h0000_5500, 1, 0, 0, 8'h00, 0, 32'h0, 0, 1, 32'h0));
    // Type 11 read, memory fill with Shared on the Snoop_done cycle: S.
    run_tx(mk(3, 32'h0000_6600, 0, 3, 0, 8'h08, 0, 32'h0, 2, 0, 32'h0BAD_F00D));

    repeat (40) run_tx(rand_tx());

    // Reset asserted while waiting on memory.
    if (!abort) begin
      @(negedge clk);
      idle_inputs();
      wait_ready();
    end
    if (!abort) begin
      Req_valid = 1'b1;
      Req_type  = 2'b00;
      Req_addr  = 32'h0000_2000;
      @(negedge clk);
      Req_valid = 1'b0;
      Bus_grant = 1'b1;
      @(negedge clk);
      @(negedge clk);
      Snoop_done = 1'b1;
      @(negedge clk);
      Snoop_done = 1'b0;
      @(negedge clk);
      check_b("rst_pre_mem_req", Mem_req, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check_b("rst_async_mem_req", Mem_req, 1'b0);
      check_b("rst_async_bus_req", Bus_req, 1'b0);
      check_b("rst_async_req_ready", Req_ready, 1'b1);
      idle_inputs();
      last_fill = '0;
      repeat (3) begin
        @(negedge clk);
        check_b("rst_no_done", Done, 1'b0);
      end
      rst_n = 1'b1;
    end
    run_tx(mk(0, 32'h0000_3000, 1, 1, 0, 8'h02, 0, 32'h0, 2, 0, 32'hA5A5_0001));
    run_tx(mk(0, 32'h0000_3040, 0, 0, 0, 8'h00, 0, 32'h0, 0, 0, 32'h5A5A_0002));

    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
